dst_pingpong_buf: RTL
=====================

// Module: dst_pingpong_buf
// PURPOSE
//  Parametrised ping-pong destination buffer. Collects DATA_W-bit core results word by word
//  into one bank while the other bank is streamed out as LANES-word beats.
//  Bank ownership moves by explicit commit/release handshakes with full/ready flags.
//  Sits between core result/out stage and the output stream DMA.
// PARAMETERS
//  DATA_W  32  width of one result word
//  LANES   2   words per stream beat; stream_d width = LANES*DATA_W; power of 2
//  BEATS   32  stream beats per bank; bank holds LANES*BEATS words; power of 2
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  asynchronous reset, active-high
//  wr_en      in   1                  write result word into current write bank
//  wr_addr    in   $clog2(LANES*BEATS) word address within bank
//  wr_data    in   DATA_W             result word
//  wr_commit  in   1                  write bank complete: hand it to reader
//  wr_ready   out  1                  current write bank is free (not full)
//  stream_v   in   1                  read request for beat stream_a
//  stream_a   in   $clog2(BEATS)      beat address within read bank
//  rd_done    in   1                  reader finished: release read bank
//  rd_ready   out  1                  current read bank is full
//  stream_d   out  LANES*DATA_W       read beat, lane i at [i*DATA_W +: DATA_W]
//  stream_dv  out  1                  stream_d valid pulse
//  err        out  1                  sticky protocol error flag
// BEHAVIOUR
//  State: full[1:0], wp (write bank), rp (read bank). Reset: full=0, wp=0, rp=0,
//   stream_d=0, stream_dv=0, err=0. Memory contents not reset.
//  wr_ready = ~full[wp]; rd_ready = full[rp]; both combinational from state.
//  Write: wr_en & wr_ready -> bank[wp] lane (wr_addr % LANES), beat (wr_addr / LANES) <= wr_data.
//   Even/odd word addresses land in lanes 0/1 for LANES=2.
//  Commit: wr_commit & wr_ready -> full[wp]<=1, wp<=~wp. A write in the same cycle
//   lands in the bank being committed.
//  Read: stream_v & rd_ready -> next cycle stream_d = bank[rp] beat stream_a, stream_dv=1.
//   Latency 1. Otherwise stream_dv=0 and stream_d holds its last value.
//  Release: rd_done & rd_ready -> full[rp]<=0, rp<=~rp. A read in the same cycle uses the old rp.
//  Commit and release in the same cycle both take effect. They always target different
//   banks or are mutually exclusive on one bank, because commit needs ~full and release needs full.
//  Both banks full: wr_ready=0; writes and commits are dropped.
//  Both banks empty: rd_ready=0; reads and releases are dropped.
//  err<=1 (sticky until rst) on any dropped op:
//   - wr_en or wr_commit while ~wr_ready;
//   - stream_v or rd_done while ~rd_ready.
//  Dropped ops change no state other than err.
//  rst asserted mid-operation: flags, pointers and outputs clear immediately. Partially
//   written banks are discarded (flags empty).
// TESTING
//  1. Reset -> wr_ready=1, rd_ready=0, stream_dv=0, stream_d=0, err=0.
//  2. Write words 0..63 with data=addr+0x100, commit, then read beats 0..31
//     -> beat k = {0x100+2k+1, 0x100+2k}, stream_dv one cycle after each stream_v; rd_ready=1.
//  3. Ping-pong: fill/commit bank0, then fill bank1 while streaming bank0; release, commit
//     -> rd_ready stays 1, second stream returns bank1 data, err=0.
//  4. Commit both banks without release -> wr_ready=0; an extra wr_en with data 0xDEAD is
//     dropped (not visible later); err=1.
//  5. stream_v and rd_done at reset state -> stream_dv=0, no pointer change, err=1.
//  6. Same-cycle wr_commit (bank1) and rd_done (bank0) with wr_en addr 63 data 0xBEEF
//     -> rp=1, wp=0, beat 31 upper lane = 0xBEEF. Repeat with LANES=4, BEATS=16.

Source files
------------

// File: rtl/dst_pingpong_buf_if.sv
// Bundles the write port, the stream read port and the status flags of the ping-pong buffer.
// The buffer itself uses the slave view; the producer, the DMA or a bench uses the master view.
interface dst_pingpong_buf_if #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int BEATS  = 32
);
    localparam int ADDR_W = $clog2(LANES * BEATS);
    localparam int BEAT_W = $clog2(BEATS);

    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      wr_commit;
    logic                      wr_ready;
    logic                      stream_v;
    logic [BEAT_W-1:0]         stream_a;
    logic                      rd_done;
    logic                      rd_ready;
    logic [LANES*DATA_W-1:0]   stream_d;
    logic                      stream_dv;
    logic                      err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_commit, stream_v, stream_a, rd_done,
        input  wr_ready, rd_ready, stream_d, stream_dv, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_commit, stream_v, stream_a, rd_done,
        output wr_ready, rd_ready, stream_d, stream_dv, err
    );
endinterface

// File: rtl/dst_pingpong_buf.sv
// Ping-pong destination buffer: one bank is filled word by word while the other is streamed
// out as LANES-word beats. Banks change hands through commit/release handshakes.
module dst_pingpong_buf #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int BEATS  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    dst_pingpong_buf_if.slave     bus
);
    localparam int LANE_W = $clog2(LANES);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int ADDR_W = LANE_W + BEAT_W;

    typedef logic [LANES-1:0][DATA_W-1:0] beat_t;

    beat_t              r_mem [2][BEATS];
    logic [1:0]         r_full;
    logic               r_wp;
    logic               r_rp;
    beat_t              r_stream_d;
    logic               r_stream_dv;
    logic               r_err;

    logic               w_wr_ready;
    logic               w_rd_ready;
    logic               w_wr;
    logic               w_commit;
    logic               w_rd;
    logic               w_release;
    logic               w_drop;
    logic [1:0]         w_full_nxt;
    logic [LANE_W-1:0]  w_lane;
    logic [BEAT_W-1:0]  w_beat;

    assign w_wr_ready = ~r_full[r_wp];
    assign w_rd_ready = r_full[r_rp];

    assign w_wr      = bus.wr_en     & w_wr_ready;
    assign w_commit  = bus.wr_commit & w_wr_ready;
    assign w_rd      = bus.stream_v  & w_rd_ready;
    assign w_release = bus.rd_done   & w_rd_ready;

    assign w_drop = ((bus.wr_en | bus.wr_commit) & ~w_wr_ready)
                  | ((bus.stream_v | bus.rd_done) & ~w_rd_ready);

    assign w_lane = bus.wr_addr[LANE_W-1:0];
    assign w_beat = bus.wr_addr[ADDR_W-1:LANE_W];

    // Commit always targets the empty write bank and release the full read bank, so both can apply at once.
    always_comb begin
        w_full_nxt = r_full;
        if (w_commit) begin
            w_full_nxt[r_wp] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rp] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full      <= 2'b00;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_stream_d  <= '0;
            r_stream_dv <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_full      <= w_full_nxt;
            r_stream_dv <= w_rd;
            r_err       <= r_err | w_drop;
            if (w_commit) begin
                r_wp <= ~r_wp;
            end
            if (w_release) begin
                r_rp <= ~r_rp;
            end
            if (w_rd) begin
                r_stream_d <= r_mem[r_rp][bus.stream_a];
            end
        end
    end

    // Storage is deliberately left out of reset; only the flags decide what a bank holds.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp][w_beat][w_lane] <= bus.wr_data;
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.rd_ready  = w_rd_ready;
    assign bus.stream_d  = r_stream_d;
    assign bus.stream_dv = r_stream_dv;
    assign bus.err       = r_err;
endmodule
